// File: rtl/parity_frame_if.sv
// Bit-serial frame bundle between the UART shifters and the parity engine.
// master: UART side drives bits/config; slave: engine returns parity/status.
interface parity_frame_if #(
    parameter int ERR_CNT_WIDTH = 8
);
    logic [2:0]               parity_type;
    logic                     frame_start;
    logic                     bit_valid;
    logic                     bit_in;
    logic                     err_clr;
    logic                     busy;
    logic                     parity_bit;
    logic                     parity_bit_vld;
    logic                     frame_done;
    logic                     parity_err;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    modport master (
        output parity_type,
        output frame_start,
        output bit_valid,
        output bit_in,
        output err_clr,
        input  busy,
        input  parity_bit,
        input  parity_bit_vld,
        input  frame_done,
        input  parity_err,
        input  err_count
    );

    modport slave (
        input  parity_type,
        input  frame_start,
        input  bit_valid,
        input  bit_in,
        input  err_clr,
        output busy,
        output parity_bit,
        output parity_bit_vld,
        output frame_done,
        output parity_err,
        output err_count
    );
endinterface

// File: rtl/parity_frame_engine.sv
// Serial parity generator/checker for the UART TX/RX datapath.
// Ports: clk, reset_n (async, active-low), bus (parity_frame_if.slave):
//   in : parity_type, frame_start, bit_valid, bit_in, err_clr
//   out: busy, parity_bit, parity_bit_vld, frame_done, parity_err, err_count
module parity_frame_engine #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    parity_frame_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] P_NONE  = 3'b000;
    localparam logic [2:0] P_ODD   = 3'b001;
    localparam logic [2:0] P_EVEN  = 3'b010;
    localparam logic [2:0] P_SPACE = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t                   state_q, state_n;
    logic                     acc_q, acc_n;
    logic [CNT_W-1:0]         cnt_q, cnt_n;
    logic [2:0]               cfg_q, cfg_n;
    logic                     done_n, err_n;
    logic                     exp_n;
    logic                     exp_cur;

    logic                     busy_q;
    logic                     pbit_q;
    logic                     pvld_q;
    logic                     done_q;
    logic                     err_q;
    logic [ERR_CNT_WIDTH-1:0] ecnt_q;

    // MARK, NONE and the reserved codes all resolve to a 1 bit.
    function automatic logic exp_parity(input logic acc, input logic [2:0] cfg);
        logic r;
        r = 1'b1;
        case (cfg)
            P_ODD:   r = ~acc;
            P_EVEN:  r = acc;
            P_SPACE: r = 1'b0;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    assign exp_cur = exp_parity(acc_q, cfg_q);

    always_comb begin
        state_n = state_q;
        acc_n   = acc_q;
        cnt_n   = cnt_q;
        cfg_n   = cfg_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        // A start pulse restarts from any state and swallows that cycle's bit.
        if (bus.frame_start) begin
            state_n = DATA;
            acc_n   = 1'b0;
            cnt_n   = '0;
            cfg_n   = bus.parity_type;
        end else begin
            case (state_q)
                DATA: begin
                    if (bus.bit_valid) begin
                        acc_n = acc_q ^ bus.bit_in;
                        cnt_n = cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            if (cfg_q == P_NONE) begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end else begin
                                state_n = PARITY;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (bus.bit_valid) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        err_n   = (bus.bit_in != exp_cur);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign exp_n = exp_parity(acc_n, cfg_n);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            cfg_q   <= P_NONE;
            busy_q  <= 1'b0;
            pbit_q  <= 1'b1;
            pvld_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            acc_q   <= acc_n;
            cnt_q   <= cnt_n;
            cfg_q   <= cfg_n;
            busy_q  <= (state_n != IDLE);
            pvld_q  <= (state_n == PARITY);
            pbit_q  <= (state_n == PARITY) ? exp_n : 1'b1;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    // Saturating error count; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ecnt_q <= '0;
        end else if (bus.err_clr) begin
            ecnt_q <= '0;
        end else if (err_n && !(&ecnt_q)) begin
            ecnt_q <= ecnt_q + 1'b1;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.parity_bit     = pbit_q;
    assign bus.parity_bit_vld = pvld_q;
    assign bus.frame_done     = done_q;
    assign bus.parity_err     = err_q;
    assign bus.err_count      = ecnt_q;

endmodule

// File: tb/tb_parity_frame_engine.sv
// Directed bench for parity_frame_engine: three instances (8/8, 7/8, 8/2)
// share one stimulus stream; each check targets the relevant instance.
module tb_parity_frame_engine;

    logic       clk;
    logic       reset_n;
    logic [2:0] ptype;
    logic       fstart;
    logic       bvalid;
    logic       bin;
    logic       eclr;

    int tests;
    int fails;
    int done_cnt;

    parity_frame_if #(.ERR_CNT_WIDTH(8)) ifa ();
    parity_frame_if #(.ERR_CNT_WIDTH(8)) ifb ();
    parity_frame_if #(.ERR_CNT_WIDTH(2)) ifc ();

    assign ifa.parity_type = ptype;
    assign ifa.frame_start = fstart;
    assign ifa.bit_valid   = bvalid;
    assign ifa.bit_in      = bin;
    assign ifa.err_clr     = eclr;
    assign ifb.parity_type = ptype;
    assign ifb.frame_start = fstart;
    assign ifb.bit_valid   = bvalid;
    assign ifb.bit_in      = bin;
    assign ifb.err_clr     = eclr;
    assign ifc.parity_type = ptype;
    assign ifc.frame_start = fstart;
    assign ifc.bit_valid   = bvalid;
    assign ifc.bit_in      = bin;
    assign ifc.err_clr     = eclr;

    parity_frame_engine #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa));
    parity_frame_engine #(.DATA_WIDTH(7), .ERR_CNT_WIDTH(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb));
    parity_frame_engine #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial done_cnt = 0;
    always @(posedge clk) begin
        if (ifa.frame_done) done_cnt = done_cnt + 1;
    end

    typedef struct {
        logic [2:0] ptype;
        logic [7:0] data;
        logic       rx;
        logic       exp_par;
        logic       exp_err;
    } vec_t;

    vec_t vt[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_frame(input logic [2:0] p);
        ptype  = p;
        fstart = 1'b1;
        step();
        fstart = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            bvalid = 1'b1;
            bin    = d[i];
            step();
        end
        bvalid = 1'b0;
        bin    = 1'b0;
    endtask

    initial begin
        int model;
        int snap;
        int ec;
        tests   = 0;
        fails   = 0;
        model   = 0;
        reset_n = 1'b0;
        ptype   = 3'b000;
        fstart  = 1'b0;
        bvalid  = 1'b0;
        bin     = 1'b0;
        eclr    = 1'b0;

        vt[0] = '{3'b010, 8'hA5, 1'b0, 1'b0, 1'b0};
        vt[1] = '{3'b001, 8'hA5, 1'b0, 1'b1, 1'b1};
        vt[2] = '{3'b001, 8'h01, 1'b0, 1'b0, 1'b0};
        vt[3] = '{3'b011, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[4] = '{3'b100, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[5] = '{3'b110, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[6] = '{3'b010, 8'hFF, 1'b1, 1'b0, 1'b1};
        vt[7] = '{3'b001, 8'h7F, 1'b0, 1'b0, 1'b0};
        vt[8] = '{3'b010, 8'h03, 1'b0, 1'b0, 1'b0};

        step();
        step();
        chk("rst_busy", ifa.busy, 0);
        chk("rst_pbit", ifa.parity_bit, 1);
        chk("rst_vld", ifa.parity_bit_vld, 0);
        chk("rst_done", ifa.frame_done, 0);
        chk("rst_err", ifa.parity_err, 0);
        chk("rst_cnt", ifa.err_count, 0);
        reset_n = 1'b1;
        step();

        // table-driven frames on the 8-bit instance
        for (int v = 0; v < 9; v++) begin
            start_frame(vt[v].ptype);
            chk($sformatf("v%0d_busy", v), ifa.busy, 1);
            send_bits(vt[v].data, 8);
            chk($sformatf("v%0d_vld", v), ifa.parity_bit_vld, 1);
            chk($sformatf("v%0d_pbit", v), ifa.parity_bit, vt[v].exp_par);
            chk($sformatf("v%0d_nodone", v), ifa.frame_done, 0);
            send_bits({7'd0, vt[v].rx}, 1);
            if (vt[v].exp_err) model = model + 1;
            chk($sformatf("v%0d_done", v), ifa.frame_done, 1);
            chk($sformatf("v%0d_err", v), ifa.parity_err, vt[v].exp_err);
            chk($sformatf("v%0d_cnt", v), ifa.err_count, model);
            chk($sformatf("v%0d_vld_off", v), ifa.parity_bit_vld, 0);
            step();
            chk($sformatf("v%0d_done_off", v), ifa.frame_done, 0);
            chk($sformatf("v%0d_idle", v), ifa.busy, 0);
        end

        // 7-bit instance, NONE: done one cycle after 7th bit, no parity phase
        start_frame(3'b000);
        for (int i = 0; i < 7; i++) begin
            bvalid = 1'b1;
            bin    = i[0];
            step();
            chk($sformatf("w7_vld%0d", i), ifb.parity_bit_vld, 0);
            chk($sformatf("w7_pbit%0d", i), ifb.parity_bit, 1);
            chk($sformatf("w7_done%0d", i), ifb.frame_done, (i == 6) ? 1 : 0);
        end
        bvalid = 1'b0;
        chk("w7_busy", ifb.busy, 0);
        step();
        chk("w7_done_off", ifb.frame_done, 0);

        // 7-bit instance, ODD over seven ones
        start_frame(3'b001);
        send_bits(8'h7F, 7);
        chk("w7o_vld", ifb.parity_bit_vld, 1);
        chk("w7o_pbit", ifb.parity_bit, 0);
        send_bits(8'h00, 1);
        chk("w7o_done", ifb.frame_done, 1);
        chk("w7o_err", ifb.parity_err, 0);
        step();

        // 2-bit saturating counter
        eclr = 1'b1;
        step();
        eclr = 1'b0;
        chk("sat_clr", ifc.err_count, 0);
        for (int k = 0; k < 5; k++) begin
            start_frame(3'b001);
            send_bits(8'hA5, 8);
            send_bits(8'h00, 1);
            ec = (k + 1 > 3) ? 3 : k + 1;
            chk($sformatf("sat_err%0d", k), ifc.parity_err, 1);
            chk($sformatf("sat_cnt%0d", k), ifc.err_count, ec);
            step();
        end
        start_frame(3'b001);
        send_bits(8'hA5, 8);
        eclr   = 1'b1;
        bvalid = 1'b1;
        bin    = 1'b0;
        step();
        eclr   = 1'b0;
        bvalid = 1'b0;
        chk("sat_clr_err", ifc.parity_err, 1);
        chk("sat_clr_win", ifc.err_count, 0);
        chk("sat_clr_a", ifa.err_count, 0);
        step();

        // config latched at frame_start
        start_frame(3'b011);
        send_bits(8'h00, 4);
        ptype = 3'b010;
        send_bits(8'h00, 4);
        chk("latch_mark", ifa.parity_bit, 1);
        send_bits(8'h01, 1);
        chk("latch_mark_err", ifa.parity_err, 0);
        step();
        start_frame(3'b100);
        send_bits(8'h00, 4);
        ptype = 3'b001;
        send_bits(8'h00, 4);
        chk("latch_space", ifa.parity_bit, 0);
        send_bits(8'h00, 1);
        chk("latch_space_err", ifa.parity_err, 0);
        step();

        // restart mid-frame; the bit in the restart cycle is dropped
        snap = done_cnt;
        start_frame(3'b010);
        send_bits(8'h0F, 4);
        chk("abort_busy", ifa.busy, 1);
        ptype  = 3'b010;
        fstart = 1'b1;
        bvalid = 1'b1;
        bin    = 1'b1;
        step();
        fstart = 1'b0;
        bvalid = 1'b0;
        bin    = 1'b0;
        chk("abort_nodone", ifa.frame_done, 0);
        send_bits(8'h03, 8);
        chk("abort_vld", ifa.parity_bit_vld, 1);
        chk("abort_pbit", ifa.parity_bit, 0);
        send_bits(8'h00, 1);
        chk("abort_err", ifa.parity_err, 0);
        step();
        step();
        chk("abort_one_done", done_cnt - snap, 1);

        // async reset in the parity phase
        start_frame(3'b001);
        send_bits(8'hA5, 8);
        chk("mrst_pre_vld", ifa.parity_bit_vld, 1);
        chk("mrst_pre_pbit", ifa.parity_bit, 1);
        snap = done_cnt;
        #1;
        reset_n = 1'b0;
        #1;
        chk("mrst_busy", ifa.busy, 0);
        chk("mrst_vld", ifa.parity_bit_vld, 0);
        chk("mrst_pbit", ifa.parity_bit, 1);
        chk("mrst_c_busy", ifc.busy, 0);
        bvalid = 1'b1;
        bin    = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        bvalid = 1'b0;
        chk("mrst_idle", ifa.busy, 0);
        chk("mrst_err", ifa.parity_err, 0);
        chk("mrst_cnt", ifa.err_count, 0);
        chk("mrst_no_done", done_cnt - snap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
